uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial bit rate.
REQ-003 SHALL have parameter DEPTH_LOG2, default 4, meaning FIFO depth of 2^DEPTH_LOG2 bytes (16).
REQ-004 SHALL have port clk  input  1  the only clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tx_data  input  8  byte to enqueue.
REQ-007 SHALL have port tx_wr  input  1  one-cycle write strobe; enqueues tx_data.
REQ-008 SHALL have port tx_full  output  1  FIFO holds 2^DEPTH_LOG2 bytes.
REQ-009 SHALL have port tx_empty  output  1  FIFO holds 0 bytes.
REQ-010 SHALL have port level  output  DEPTH_LOG2+1  current FIFO occupancy.
REQ-011 SHALL have port overflow  output  1  sticky flag: a write was dropped.
REQ-012 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-013 SHALL have port TxD  output  1  serial line, 8N1, idle high.

Function
REQ-014 SHALL compute bit period DIV = (CLK_HZ + BAUD/2) / BAUD clock cycles at elaboration (434 at defaults); DIV >= 2 required.
REQ-015 SHALL store tx_data into FIFO on any clk edge where tx_wr=1 and tx_full=0.
REQ-016 SHALL drop the byte and set overflow=1 when tx_wr=1 and tx_full=1, even if a pop occurs in the same cycle; FIFO contents unchanged by the dropped write.
REQ-017 SHALL update level by +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
REQ-018 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-019 IDLE: TxD=1; if FIFO non-empty, pop head byte into shift register and enter START on that edge.
REQ-020 START: TxD=0 for exactly DIV cycles, then DATA.
REQ-021 DATA: drive 8 bits LSB first, each for exactly DIV cycles, via 3-bit bit index; after bit 7 enter STOP.
REQ-022 STOP: TxD=1 for exactly DIV cycles; on last cycle, if FIFO non-empty, pop and enter START directly (zero idle gap), else enter IDLE.
REQ-023 Frame length SHALL be exactly 10*DIV cycles; back-to-back frames SHALL be contiguous.
REQ-024 Latency: tx_wr in cycle n with FSM IDLE and FIFO empty -> TxD low from cycle n+2.
REQ-025 TxD SHALL be driven from a register (glitch-free).
REQ-026 FIFO pointers SHALL wrap modulo 2^DEPTH_LOG2; full/empty derived from level, never ambiguous.
REQ-027 A byte popped into the shift register SHALL be transmitted intact regardless of subsequent FIFO writes.

Reset
REQ-028 On rst=1 at a clk edge: FSM=IDLE, TxD=1, busy=0, level=0, tx_empty=1, tx_full=0, overflow=0, pointers, bit index and baud counter cleared.
REQ-029 rst mid-frame SHALL abort the frame immediately (TxD=1 next cycle) and discard all queued bytes.
REQ-030 tx_wr during rst=1 SHALL be ignored.

Verification (CLK_HZ=1000000, BAUD=250000, DIV=4)
REQ-031 Write 0xA5 once from idle -> TxD from cycle n+2: 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; busy high 40 cycles; tx_empty=1 after pop.
REQ-032 Write 0x00, 0xFF in consecutive cycles -> two contiguous 40-cycle frames, no idle high between STOP of first and START of second.
REQ-033 Write 17 bytes 0x01..0x11 in 17 consecutive cycles -> first byte popped after cycle 1 so all 17 accepted or 17th dropped per REQ-016 timing; check level, tx_full and overflow against cycle-exact model; all accepted bytes transmitted in order.
REQ-034 With FIFO full and frame in progress, tx_wr=1 -> overflow=1, level stays 16, transmitted sequence unchanged.
REQ-035 Assert rst at bit 3 of a frame with 5 bytes queued -> next cycle TxD=1, busy=0, level=0, overflow=0; no further frames.
REQ-036 Simultaneous write and pop at level=3 -> level remains 3, written byte transmitted after the two older ones.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide transmit FIFO feeding an 8N1 UART serializer.
//
// Ports:
//   clk       in   single clock, everything on the rising edge
//   rst       in   synchronous, active-high reset (aborts frame, flushes FIFO)
//   tx_data   in   [7:0] byte to enqueue
//   tx_wr     in   write strobe, enqueues tx_data when the FIFO is not full
//   tx_full   out  FIFO holds 2^DEPTH_LOG2 bytes
//   tx_empty  out  FIFO holds no bytes
//   level     out  [DEPTH_LOG2:0] FIFO occupancy
//   overflow  out  sticky: a write arrived while full and was dropped
//   busy      out  serializer is not idle
//   TxD       out  registered serial line, idle high
//
// The bit period DIV is rounded to the nearest whole clock count and must be
// at least 2.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            tx_data,
  input  logic                  tx_wr,
  output logic                  tx_full,
  output logic                  tx_empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  busy,
  output logic                  TxD
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [7:0]              shreg_q, shreg_d;
  logic                    txd_q, txd_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    overflow_q, overflow_d;
  logic [7:0]              mem_q [DEPTH];

  logic full, empty, wr_en, pop, cnt_last;
  logic [7:0] head;

  // Full/empty come from the occupancy count, so equal pointers are never ambiguous.
  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign wr_en    = tx_wr & ~full;
  assign head     = mem_q[rd_ptr_q];
  assign cnt_last = (cnt_q == CNT_LAST);

  assign tx_full  = full;
  assign tx_empty = empty;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != S_IDLE);
  assign TxD      = txd_q;

  // State register and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      txd_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      txd_q      <= txd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
    shreg_q <= shreg_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= tx_data;
  end

  // Next-state: serializer FSM and FIFO pointers
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_last) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) state_d   = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q | (tx_wr & full);
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Output: line level for the coming cycle, registered into txd_q
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shreg_d[bit_idx_d];
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int CLK_HZ     = 1000000;
  localparam int BAUD       = 250000;
  localparam int DEPTH_LOG2 = 4;
  localparam int DIV        = 4;
  localparam int DEPTH      = 16;
  localparam int FRAME      = 10 * DIV;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                tx_wr = 1'b0;
  logic [7:0]          tx_data = 8'h00;
  logic                tx_full, tx_empty, overflow, busy, TxD;
  logic [DEPTH_LOG2:0] level;

  uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_full(tx_full), .tx_empty(tx_empty), .level(level),
    .overflow(overflow), .busy(busy), .TxD(TxD)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a byte queue plus a frame timer counting cycles into the frame.
  byte unsigned m_q[$];
  bit           m_active  = 1'b0;
  int           m_elapsed = 0;
  byte unsigned m_byte    = 8'h00;
  bit           m_ovf     = 1'b0;
  byte unsigned exp_rx[$];
  byte unsigned got_rx[$];

  // Line decoder state
  bit           rx_on  = 1'b0;
  int           rx_cnt = 0;
  byte unsigned rx_sh  = 8'h00;

  typedef struct packed {
    bit       r;
    bit       w;
    bit [7:0] d;
    bit [4:0] lvl;
    bit       full;
    bit       empty;
    bit       ovf;
    bit       bsy;
    bit       txd;
  } vec_t;

  vec_t tbl[9];
  int   busy_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_txd();
    int k;
    if (!m_active) return 1;
    k = m_elapsed / DIV;
    if (k == 0) return 0;
    if (k == 9) return 1;
    return (m_byte >> (k - 1)) & 1;
  endfunction

  task automatic model_edge(input bit r, input bit w, input byte unsigned d);
    int sz;
    bit do_pop;
    if (r) begin
      if (m_active) void'(exp_rx.pop_back());
      m_q.delete();
      m_active  = 1'b0;
      m_elapsed = 0;
      m_ovf     = 1'b0;
      return;
    end
    sz     = m_q.size();
    do_pop = (sz > 0) && (!m_active || m_elapsed == FRAME - 1);
    if (w && sz == DEPTH) m_ovf = 1'b1;
    if (do_pop) begin
      m_byte    = m_q.pop_front();
      exp_rx.push_back(m_byte);
      m_active  = 1'b1;
      m_elapsed = 0;
    end else if (m_active) begin
      m_elapsed++;
      if (m_elapsed == FRAME) begin
        m_active  = 1'b0;
        m_elapsed = 0;
      end
    end
    if (w && sz < DEPTH) m_q.push_back(d);
  endtask

  task automatic step(input bit r, input bit w, input byte unsigned d);
    rst     = r;
    tx_wr   = w;
    tx_data = d;
    @(posedge clk);
    model_edge(r, w, d);
    #1;
    check("level",    level,    m_q.size());
    check("tx_full",  tx_full,  (m_q.size() == DEPTH) ? 1 : 0);
    check("tx_empty", tx_empty, (m_q.size() == 0) ? 1 : 0);
    check("overflow", overflow, m_ovf);
    check("busy",     busy,     m_active);
    check("TxD",      TxD,      m_txd());
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((busy || !tx_empty) && k < 2000) begin
      step(1'b0, 1'b0, 8'h00);
      k++;
    end
    check({name, "_drain_timeout"}, (k < 2000) ? 1 : 0, 1);
    repeat (3) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_rx(input string name);
    check({name, "_rx_count"}, got_rx.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < got_rx.size(); i++)
      check({name, "_rx_byte"}, got_rx[i], exp_rx[i]);
    got_rx.delete();
    exp_rx.delete();
  endtask

  // Independent line decoder: samples each bit at mid-period.
  initial begin : decoder
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_on = 1'b0;
      end else if (!rx_on) begin
        if (TxD == 1'b0) begin
          rx_on  = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt >= DIV + DIV / 2 && rx_cnt <= 8 * DIV + DIV / 2 && ((rx_cnt - DIV / 2) % DIV) == 0)
          rx_sh[(rx_cnt - DIV / 2) / DIV - 1] = TxD;
        if (rx_cnt == 9 * DIV + DIV / 2) begin
          check("stop_bit", TxD, 1);
          got_rx.push_back(rx_sh);
          rx_on = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cnt;
    int k;

    //          r  w  d      lvl full empty ovf busy txd
    tbl[0] = '{1'b1, 1'b1, 8'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset with an ignored write, then one 0xA5 frame.
    busy_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].d);
      check($sformatf("tbl%0d_level", i),    level,    tbl[i].lvl);
      check($sformatf("tbl%0d_full", i),     tx_full,  tbl[i].full);
      check($sformatf("tbl%0d_empty", i),    tx_empty, tbl[i].empty);
      check($sformatf("tbl%0d_overflow", i), overflow, tbl[i].ovf);
      check($sformatf("tbl%0d_busy", i),     busy,     tbl[i].bsy);
      check($sformatf("tbl%0d_txd", i),      TxD,      tbl[i].txd);
      busy_cnt += busy;
    end
    k = 0;
    while (busy && k < 200) begin
      step(1'b0, 1'b0, 8'h00);
      busy_cnt += busy;
      k++;
    end
    check("a5_busy_cycles", busy_cnt, FRAME);
    drain("a5");
    check_rx("a5");

    // Two back-to-back frames with no idle gap.
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    cnt = 0;
    while (busy && cnt < 300) begin
      cnt++;
      step(1'b0, 1'b0, 8'h00);
    end
    check("b2b_busy_cycles", cnt, 2 * FRAME);
    drain("b2b");
    check_rx("b2b");

    // 17-byte burst from idle, then a write into a full FIFO.
    for (int i = 1; i <= 17; i++) step(1'b0, 1'b1, byte'(i));
    check("burst_level", level, 16);
    check("burst_full", tx_full, 1);
    check("burst_overflow", overflow, 0);
    step(1'b0, 1'b1, 8'h99);
    check("full_wr_overflow", overflow, 1);
    check("full_wr_level", level, 16);
    drain("burst");
    check_rx("burst");

    // Write coinciding with the pop at the end of a stop bit, level 3.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, byte'(8'h31 + i));
    k = 0;
    while (!(level == 3 && m_active && m_elapsed == FRAME - 1) && k < 500) begin
      step(1'b0, 1'b0, 8'h00);
      k++;
    end
    check("simul_wait_timeout", (k < 500) ? 1 : 0, 1);
    step(1'b0, 1'b1, 8'h77);
    check("simul_level", level, 3);
    drain("simul");
    check_rx("simul");

    // Reset during data bit 3 with five bytes queued.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, byte'(8'hC0 + i));
    k = 0;
    while (!(m_active && m_elapsed == 4 * DIV + 1) && k < 200) begin
      step(1'b0, 1'b0, 8'h00);
      k++;
    end
    check("rst_wait_timeout", (k < 200) ? 1 : 0, 1);
    check("rst_pre_level", level, 5);
    check("rst_pre_overflow", overflow, 1);
    step(1'b1, 1'b0, 8'h00);
    check("rst_txd", TxD, 1);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    repeat (100) step(1'b0, 1'b0, 8'h00);
    check_rx("rst_abort");

    // Randomized traffic at several write densities.
    for (int ph = 0; ph < 4; ph++) begin
      int p;
      p = (ph == 0) ? 2 : (ph == 1) ? 10 : (ph == 2) ? 40 : 90;
      for (int c = 0; c < 500; c++) begin
        bit w;
        w = (($urandom % 100) < p);
        step(1'b0, w, byte'($urandom));
      end
    end
    drain("rand");
    check_rx("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
